// File: rtl/bcd_seq_ctrl.sv
// Sequential binary-to-BCD (double-dabble) converter driving four active-low 7-segment displays.
// Optional macro LEADING_ZERO_BLANK_EN blanks displays above the highest nonzero digit.
module bcd_seq_ctrl #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] bin_in,
  output logic         busy,
  output logic         done,
  output logic [15:0]  bcd_out,
  output logic [0:6]   display_unidad,
  output logic [0:6]   display_decena,
  output logic [0:6]   display_centena,
  output logic [0:6]   display_mil,
  output logic [1:0]   state_dbg
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:6] SEG_ZERO  = 7'b0000001;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [0:6] SEG_UPPER_RST = SEG_BLANK;
`else
  localparam logic [0:6] SEG_UPPER_RST = SEG_ZERO;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [N+15:0]   sr;
  logic [N+15:0]   sr_adj;
  logic [N+15:0]   sr_next;
  logic [15:0]     new_bcd;
  logic            blank_mil;
  logic            blank_centena;
  logic            blank_decena;

  assign state_dbg = state;

  function automatic logic [0:6] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // One double-dabble step: add-3 correction on the BCD nibbles, then shift left.
  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < 4; i++) begin
      if (sr[N+4*i +: 4] >= 4'd5)
        sr_adj[N+4*i +: 4] = sr[N+4*i +: 4] + 4'd3;
    end
    sr_next = sr_adj << 1;
    new_bcd = sr_next[N+15:N];
  end

  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    blank_mil     = (new_bcd[15:12] == 4'd0);
    blank_centena = blank_mil && (new_bcd[11:8] == 4'd0);
    blank_decena  = blank_centena && (new_bcd[7:4] == 4'd0);
`else
    blank_mil     = 1'b0;
    blank_centena = 1'b0;
    blank_decena  = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      sr              <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      bcd_out         <= 16'h0000;
      display_unidad  <= SEG_ZERO;
      display_decena  <= SEG_UPPER_RST;
      display_centena <= SEG_UPPER_RST;
      display_mil     <= SEG_UPPER_RST;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr    <= {16'b0, bin_in};
            cnt   <= CW'(N - 1);
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sr  <= sr_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state           <= DONE;
            busy            <= 1'b0;
            done            <= 1'b1;
            bcd_out         <= new_bcd;
            display_unidad  <= seg7(new_bcd[3:0]);
            display_decena  <= blank_decena  ? SEG_BLANK : seg7(new_bcd[7:4]);
            display_centena <= blank_centena ? SEG_BLANK : seg7(new_bcd[11:8]);
            display_mil     <= blank_mil     ? SEG_BLANK : seg7(new_bcd[15:12]);
          end
        end
        DONE: begin
          // A start held through DONE chains straight into the next conversion.
          if (start) begin
            sr    <= {16'b0, bin_in};
            cnt   <= CW'(N - 1);
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
